bit_compare_checker: RTL and testbench
======================================

Name: bit_compare_checker

Overview:
- Synthesizable response checker for the 1-bit comparator block: it consumes applied stimulus (a, b) together with the comparator's outputs (c, d, e, f).
- Computes expected outputs, counts vectors and mismatches, and latches the first failing vector.
- Sits on the opposite end of the stimulus path, so on-board self-test needs no simulator.

Parameters:
- NUM_VECTORS, 4, number of vectors accepted per run before DONE (min 1).
- CNT_W, 8, width of vector/error counters; must satisfy 2^CNT_W > NUM_VECTORS.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- start  input  1  one-cycle pulse; begins a run from IDLE or DONE
- in_valid  input  1  a,b,c,d,e,f valid this cycle
- a  input  1  applied stimulus bit A
- b  input  1  applied stimulus bit B
- c  input  1  DUT output: equal
- d  input  1  DUT output: A greater than B
- e  input  1  DUT output: A less than B
- f  input  1  DUT output: not equal
- busy  output  1  run in progress
- done  output  1  run complete (level, held until start/rst)
- pass  output  1  done and err_cnt==0
- vec_cnt  output  CNT_W  vectors checked this run
- err_cnt  output  CNT_W  mismatching vectors this run
- fail_valid  output  1  a mismatch has been latched
- fail_vec  output  6  first failing {a,b,c,d,e,f}

Behaviour:
- Interface: one clock clk; reset rst is synchronous and active-high.
- Reset: state=IDLE; busy, done, pass, fail_valid = 0; vec_cnt, err_cnt = 0; fail_vec = 0; pipeline valid bits = 0.
- Expected function: c = ~(a^b), d = a&~b, e = ~a&b, f = a^b. A vector mismatches if any of the four bits differs.
- Pipeline, 2 stages:
  - S1 registers {in_valid, a, b, c, d, e, f}.
  - S2 compares and updates counters.
  - Counters and fail_vec reflect an accepted vector 2 cycles after in_valid is sampled.
- FSM IDLE -> RUN -> DRAIN -> DONE:
  - IDLE: in_valid ignored. start -> RUN; clear counters, fail_valid and fail_vec in the same edge.
  - RUN: each in_valid cycle is accepted into S1, and an internal accept count increments. When the accept count reaches NUM_VECTORS, go to DRAIN; further in_valid is ignored.
  - DRAIN: wait until S1 and S2 are empty (2 cycles), then go to DONE.
  - DONE: done=1, pass=(err_cnt==0). start -> RUN with counters cleared.
- busy = 1 in RUN and DRAIN.
- First-fail latch: on the first mismatching vector in S2, fail_vec is loaded and fail_valid is set. Later mismatches only increment err_cnt.
- Counter width: vec_cnt and err_cnt saturate at 2^CNT_W-1 and never wrap.
- start while busy: ignored.
- start and in_valid in the same IDLE cycle: that in_valid is not accepted (acceptance begins the cycle after RUN is entered).
- rst mid-run: returns to IDLE next edge; in-flight S1/S2 vectors are discarded; all outputs go to reset values.
- NUM_VECTORS reached with in_valid gaps: gaps are legal; DONE only after exactly NUM_VECTORS accepted vectors are checked.

Decomposition:
- Shared package bit_compare_pkg:
  - FSM state typedef (IDLE, RUN, DRAIN, DONE).
  - Function bit_compare_expect(a, b) returning the 4-bit {c,d,e,f}, reused by the comparator RTL and the bench model.
- One natural sub-module: bit_compare_golden, the combinational expected-output generator instantiated in S2.
- FSM, pipeline and counters stay in the top module.

Test Plan:
- Correct DUT, NUM_VECTORS=4, vectors ab=00,01,10,11 back-to-back after start -> 6 cycles later done=1, pass=1, vec_cnt=4, err_cnt=0, fail_valid=0.
- Fault on ab=10 (d forced 0, cdef=0001) among 4 vectors -> done=1, pass=0, err_cnt=1, fail_valid=1, fail_vec=6'b10_0001.
- Two faults (ab=01 cdef=0000, then ab=11 cdef=0000) -> err_cnt=2, fail_vec=6'b01_0000 (first retained).
- in_valid with 2-cycle gaps plus a fifth vector after the fourth -> vec_cnt=4; fifth ignored; DONE only after the fourth is checked.
- rst asserted one cycle after the second vector -> next edge: busy=0, done=0, vec_cnt=0, err_cnt=0, fail_valid=0; a following start runs cleanly to pass=1.
- start during RUN, and start in DONE -> first ignored (counts continue); second clears counters and re-enters RUN with busy=1, done=0.

Source files
------------

// File: rtl/bit_compare_pkg.sv
// Shared types and helpers for the 1-bit comparator response checker.
// Contents:
//   state_t            - checker FSM states
//   VEC_W / EXP_W      - widths of a captured vector {a,b,c,d,e,f} and of {c,d,e,f}
//   bit_compare_expect - reference comparator function, used by RTL and bench alike
package bit_compare_pkg;

  localparam int unsigned VEC_W = 6;
  localparam int unsigned EXP_W = 4;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } state_t;

  // Returns {c, d, e, f} = {equal, a>b, a<b, not equal}.
  function automatic logic [EXP_W-1:0] bit_compare_expect(input logic a, input logic b);
    return {~(a ^ b), a & ~b, ~a & b, a ^ b};
  endfunction

endpackage

// File: rtl/bit_compare_checker_if.sv
// Bus between a stimulus/response source and the bit_compare_checker.
// Signals:
//   start, in_valid, a, b, c, d, e, f  - source -> checker
//   busy, done, pass, vec_cnt, err_cnt,
//   fail_valid, fail_vec               - checker -> source
// Modports: master (source side), slave (checker side).
interface bit_compare_checker_if
  import bit_compare_pkg::*;
#(
  parameter int unsigned CNT_W = 8
);

  logic             start;
  logic             in_valid;
  logic             a;
  logic             b;
  logic             c;
  logic             d;
  logic             e;
  logic             f;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] vec_cnt;
  logic [CNT_W-1:0] err_cnt;
  logic             fail_valid;
  logic [VEC_W-1:0] fail_vec;

  modport master (
    output start, in_valid, a, b, c, d, e, f,
    input  busy, done, pass, vec_cnt, err_cnt, fail_valid, fail_vec
  );

  modport slave (
    input  start, in_valid, a, b, c, d, e, f,
    output busy, done, pass, vec_cnt, err_cnt, fail_valid, fail_vec
  );

endinterface

// File: rtl/bit_compare_golden.sv
// Combinational expected-output generator for the 1-bit comparator.
// Ports:
//   i_a, i_b - applied stimulus bits
//   o_exp    - expected {c, d, e, f}
module bit_compare_golden
  import bit_compare_pkg::*;
(
  input  logic             i_a,
  input  logic             i_b,
  output logic [EXP_W-1:0] o_exp
);

  always_comb begin
    o_exp = bit_compare_expect(i_a, i_b);
  end

endmodule

// File: rtl/bit_compare_checker.sv
// Response checker for the 1-bit comparator. Accepts NUM_VECTORS vectors per run through a
// two-stage pipeline (S1 capture, S2 compare/count), counts checked and mismatching vectors
// and latches the first failing vector.
// Ports:
//   i_clk - rising-edge clock
//   i_rst - synchronous active-high reset
//   bus   - checker side of bit_compare_checker_if (stimulus/response in, status out)
module bit_compare_checker
  import bit_compare_pkg::*;
#(
  parameter int unsigned NUM_VECTORS = 4,
  parameter int unsigned CNT_W       = 8
) (
  input logic                  i_clk,
  input logic                  i_rst,
  bit_compare_checker_if.slave bus
);

  localparam logic [CNT_W-1:0] LastAcc = CNT_W'(NUM_VECTORS - 1);
  localparam logic [CNT_W-1:0] CntMax  = {CNT_W{1'b1}};

  state_t             r_state;
  state_t             w_state_next;
  logic               w_accept;
  logic               w_clear;

  logic [CNT_W-1:0]   r_acc_cnt;
  logic               r_s1_valid;
  logic [VEC_W-1:0]   r_s1_vec;

  logic [EXP_W-1:0]   w_exp;
  logic               w_mismatch;

  logic [CNT_W-1:0]   r_vec_cnt;
  logic [CNT_W-1:0]   r_err_cnt;
  logic               r_fail_valid;
  logic [VEC_W-1:0]   r_fail_vec;

  // ---------------------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_clear      = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (bus.start) begin
          w_state_next = StRun;
          w_clear      = 1'b1;
        end
      end
      StRun: begin
        if (bus.in_valid) begin
          w_accept = 1'b1;
          if (r_acc_cnt == LastAcc) begin
            w_state_next = StDrain;
          end
        end
      end
      StDrain: begin
        // S2 retires a vector on the same edge S1 hands it over, so once S1 is empty the
        // last vector has been counted and both stages are clear.
        if (!r_s1_valid) begin
          w_state_next = StDone;
        end
      end
      StDone: begin
        if (bus.start) begin
          w_state_next = StRun;
          w_clear      = 1'b1;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  // ---------------------------------------------------------------------------------------
  // S1: capture accepted vectors
  // ---------------------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1_valid <= 1'b0;
      r_s1_vec   <= '0;
      r_acc_cnt  <= '0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_vec <= {bus.a, bus.b, bus.c, bus.d, bus.e, bus.f};
      end
      if (w_clear) begin
        r_acc_cnt <= '0;
      end else if (w_accept) begin
        r_acc_cnt <= r_acc_cnt + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------------------
  // S2: compare against the golden model and update counters / first-fail latch
  // ---------------------------------------------------------------------------------------
  bit_compare_golden u_golden (
    .i_a   (r_s1_vec[5]),
    .i_b   (r_s1_vec[4]),
    .o_exp (w_exp)
  );

  always_comb begin
    w_mismatch = r_s1_valid && (r_s1_vec[EXP_W-1:0] != w_exp);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_vec_cnt    <= '0;
      r_err_cnt    <= '0;
      r_fail_valid <= 1'b0;
      r_fail_vec   <= '0;
    end else if (w_clear) begin
      // Start is only honoured in IDLE/DONE, where S1 is empty, so no vector is lost here.
      r_vec_cnt    <= '0;
      r_err_cnt    <= '0;
      r_fail_valid <= 1'b0;
      r_fail_vec   <= '0;
    end else if (r_s1_valid) begin
      if (r_vec_cnt != CntMax) begin
        r_vec_cnt <= r_vec_cnt + 1'b1;
      end
      if (w_mismatch) begin
        if (r_err_cnt != CntMax) begin
          r_err_cnt <= r_err_cnt + 1'b1;
        end
        if (!r_fail_valid) begin
          r_fail_valid <= 1'b1;
          r_fail_vec   <= r_s1_vec;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------------------
  assign bus.busy       = (r_state == StRun) || (r_state == StDrain);
  assign bus.done       = (r_state == StDone);
  assign bus.pass       = (r_state == StDone) && (r_err_cnt == '0);
  assign bus.vec_cnt    = r_vec_cnt;
  assign bus.err_cnt    = r_err_cnt;
  assign bus.fail_valid = r_fail_valid;
  assign bus.fail_vec   = r_fail_vec;

endmodule

// File: tb/tb_bit_compare_checker.sv
// Directed self-checking bench for bit_compare_checker (NUM_VECTORS=4, CNT_W=8).
// Inputs change 1 time unit after a rising edge; outputs are checked at the same point.
module tb_bit_compare_checker;
  import bit_compare_pkg::*;

  // Correct {a,b,c,d,e,f} vectors, worked out by hand.
  localparam logic [5:0] V00 = 6'b00_1000;
  localparam logic [5:0] V01 = 6'b01_0011;
  localparam logic [5:0] V10 = 6'b10_0101;
  localparam logic [5:0] V11 = 6'b11_1000;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  bit_compare_checker_if #(.CNT_W(8)) bus ();

  bit_compare_checker #(
    .NUM_VECTORS (4),
    .CNT_W       (8)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (observed timeout, required $finish)");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [5:0] v);
    bus.in_valid = 1'b1;
    {bus.a, bus.b, bus.c, bus.d, bus.e, bus.f} = v;
    step(1);
    bus.in_valid = 1'b0;
  endtask

  task automatic start_pulse();
    bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    {bus.a, bus.b, bus.c, bus.d, bus.e, bus.f} = 6'b0;
    step(2);

    // Reset state
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_pass", 32'(bus.pass), 32'd0);
    chk("rst_vec_cnt", 32'(bus.vec_cnt), 32'd0);
    chk("rst_err_cnt", 32'(bus.err_cnt), 32'd0);
    chk("rst_fail_valid", 32'(bus.fail_valid), 32'd0);
    chk("rst_fail_vec", 32'(bus.fail_vec), 32'd0);
    rst = 1'b0;
    step(1);

    // in_valid in IDLE is ignored
    send(6'b00_0000);
    step(3);
    chk("idle_ignore_vec", 32'(bus.vec_cnt), 32'd0);
    chk("idle_ignore_err", 32'(bus.err_cnt), 32'd0);

    // T1: four correct vectors back to back
    start_pulse();
    chk("t1_busy", 32'(bus.busy), 32'd1);
    chk("t1_not_done", 32'(bus.done), 32'd0);
    send(V00);
    send(V01);
    send(V10);
    send(V11);
    chk("t1_vec_pipe", 32'(bus.vec_cnt), 32'd3);
    chk("t1_busy_drain", 32'(bus.busy), 32'd1);
    step(1);
    chk("t1_drain_done", 32'(bus.done), 32'd0);
    chk("t1_drain_vec", 32'(bus.vec_cnt), 32'd4);
    step(1);
    chk("t1_done", 32'(bus.done), 32'd1);
    chk("t1_pass", 32'(bus.pass), 32'd1);
    chk("t1_busy_off", 32'(bus.busy), 32'd0);
    chk("t1_vec", 32'(bus.vec_cnt), 32'd4);
    chk("t1_err", 32'(bus.err_cnt), 32'd0);
    chk("t1_fail_valid", 32'(bus.fail_valid), 32'd0);

    // T2: single fault on ab=10 (d stuck at 0)
    start_pulse();
    chk("t2_clr_vec", 32'(bus.vec_cnt), 32'd0);
    chk("t2_busy", 32'(bus.busy), 32'd1);
    chk("t2_not_done", 32'(bus.done), 32'd0);
    send(V00);
    send(V01);
    send(6'b10_0001);
    send(V11);
    step(2);
    chk("t2_done", 32'(bus.done), 32'd1);
    chk("t2_pass", 32'(bus.pass), 32'd0);
    chk("t2_err", 32'(bus.err_cnt), 32'd1);
    chk("t2_fail_valid", 32'(bus.fail_valid), 32'd1);
    chk("t2_fail_vec", 32'(bus.fail_vec), 32'(6'b10_0001));

    // T3: two faults, first one retained
    start_pulse();
    send(V00);
    send(6'b01_0000);
    send(V10);
    send(6'b11_0000);
    step(2);
    chk("t3_done", 32'(bus.done), 32'd1);
    chk("t3_err", 32'(bus.err_cnt), 32'd2);
    chk("t3_vec", 32'(bus.vec_cnt), 32'd4);
    chk("t3_fail_vec", 32'(bus.fail_vec), 32'(6'b01_0000));

    // T4: gaps between vectors plus a faulty fifth vector that must be ignored
    start_pulse();
    send(V00);
    step(2);
    chk("t4_gap_vec", 32'(bus.vec_cnt), 32'd1);
    chk("t4_gap_busy", 32'(bus.busy), 32'd1);
    chk("t4_gap_done", 32'(bus.done), 32'd0);
    send(V01);
    step(2);
    send(V10);
    step(2);
    send(V11);
    send(6'b11_0000);
    chk("t4_pre_done", 32'(bus.done), 32'd0);
    chk("t4_pre_vec", 32'(bus.vec_cnt), 32'd4);
    step(1);
    chk("t4_done", 32'(bus.done), 32'd1);
    chk("t4_vec", 32'(bus.vec_cnt), 32'd4);
    chk("t4_err", 32'(bus.err_cnt), 32'd0);
    chk("t4_pass", 32'(bus.pass), 32'd1);
    step(3);
    chk("t4_vec_hold", 32'(bus.vec_cnt), 32'd4);

    // T5: reset mid-run, then start together with in_valid
    start_pulse();
    send(6'b00_0000);
    send(V01);
    chk("t5_err_before", 32'(bus.err_cnt), 32'd1);
    chk("t5_fv_before", 32'(bus.fail_valid), 32'd1);
    rst = 1'b1;
    step(1);
    chk("t5_rst_busy", 32'(bus.busy), 32'd0);
    chk("t5_rst_done", 32'(bus.done), 32'd0);
    chk("t5_rst_vec", 32'(bus.vec_cnt), 32'd0);
    chk("t5_rst_err", 32'(bus.err_cnt), 32'd0);
    chk("t5_rst_fv", 32'(bus.fail_valid), 32'd0);
    chk("t5_rst_fail_vec", 32'(bus.fail_vec), 32'd0);
    rst = 1'b0;
    step(2);
    chk("t5_discard_vec", 32'(bus.vec_cnt), 32'd0);
    bus.start    = 1'b1;
    bus.in_valid = 1'b1;
    {bus.a, bus.b, bus.c, bus.d, bus.e, bus.f} = 6'b00_0000;
    step(1);
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    send(V00);
    send(V01);
    send(V10);
    send(V11);
    step(2);
    chk("t5_done", 32'(bus.done), 32'd1);
    chk("t5_pass", 32'(bus.pass), 32'd1);
    chk("t5_vec", 32'(bus.vec_cnt), 32'd4);
    chk("t5_err", 32'(bus.err_cnt), 32'd0);

    // T6: start while busy is ignored; start in DONE clears and reruns
    start_pulse();
    send(V00);
    send(6'b01_0000);
    bus.start = 1'b1;
    send(V10);
    bus.start = 1'b0;
    chk("t6_busy_start_busy", 32'(bus.busy), 32'd1);
    chk("t6_busy_start_vec", 32'(bus.vec_cnt), 32'd2);
    chk("t6_busy_start_err", 32'(bus.err_cnt), 32'd1);
    send(V11);
    step(2);
    chk("t6_done", 32'(bus.done), 32'd1);
    chk("t6_vec", 32'(bus.vec_cnt), 32'd4);
    chk("t6_err", 32'(bus.err_cnt), 32'd1);
    start_pulse();
    chk("t6_rerun_busy", 32'(bus.busy), 32'd1);
    chk("t6_rerun_done", 32'(bus.done), 32'd0);
    chk("t6_rerun_vec", 32'(bus.vec_cnt), 32'd0);
    chk("t6_rerun_err", 32'(bus.err_cnt), 32'd0);
    chk("t6_rerun_fv", 32'(bus.fail_valid), 32'd0);
    chk("t6_rerun_fail_vec", 32'(bus.fail_vec), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
